mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

- Two-port access controller for the 32 × 8 single-port data memory with a shared tri-state data bus.
- Arbitrates between requester 0 (instruction fetch) and requester 1 (load/store unit).
- Sequences each granted request into a read or write cycle on the memory's `addr`/`rd`/`wr`/`data` pins and returns a one-cycle acknowledge with latched read data.
- Sits between the CPU core's fetch and execute stages and the memory instance.

## Interface
Parameters:
- `ADDR_W`, 5, memory address width
- `DATA_W`, 8, memory data width

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  access request, held until the matching ack
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req is high
- `addr0`, `addr1`  in  ADDR_W  access address; stable while req is high
- `wdata0`, `wdata1`  in  DATA_W  write data; stable while req is high
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `rdata0`, `rdata1`  out  DATA_W  last read result for that port; valid from the ack cycle and held until the next read by that port
- `mem_addr`  out  ADDR_W  memory address
- `mem_rd`  out  1  memory read enable
- `mem_wr`  out  1  memory write enable
- `mem_data`  inout  DATA_W  shared bidirectional data bus

## Operation
- FSM states: IDLE, RD, WR, ACK.
- **IDLE:** if any req is high, pick a winner (see arbitration), latch its addr/wdata/we and the winner index, then go to WR if we = 1, else RD. With no request, stay in IDLE.
- **RD:** mem_rd = 1, mem_wr = 0, mem_data released (Z). At the clock edge, capture mem_data into the winner's rdata, then go to ACK.
- **WR:** mem_wr = 1, mem_rd = 0, controller drives mem_data with the latched wdata. The memory writes at the clock edge, then go to ACK.
- **ACK:** the winner's ack = 1; mem_rd = mem_wr = 0; bus Z. Always go to IDLE.
- mem_rd and mem_wr are never both 1. The controller drives mem_data only in WR.
- mem_addr holds the latched address in RD, WR and ACK, and keeps its last value in IDLE.
- Arbitration (fixed priority): req0 wins whenever it is high.
- A req still high in the IDLE cycle after its ack is treated as a new request.
- Writes leave both rdata registers unchanged.

## Timing
- req sampled high at edge n, then RD/WR during cycle n+1, then ack during cycle n+2, then IDLE in cycle n+3.
- Fixed 3-cycle access; peak throughput is one access per 3 cycles.
- rdata is updated at the edge entering ACK, so it is valid in the same cycle as ack.
- Reset values: state IDLE; mem_addr 0; mem_rd 0; mem_wr 0; mem_data Z; ack0/ack1 0; rdata0/rdata1 0; round-robin pointer = "last grant was port 1".
- Reset mid-access (asserting rst_n low in RD, WR or ACK):
  - mem_rd/mem_wr drop and the bus goes Z immediately (asynchronous).
  - The in-flight request is discarded: no ack is issued.
  - A WR interrupted before its edge does not write.
- A request that arrives in RD/WR/ACK waits until IDLE; no request is ever dropped.

## Configuration
- `MEM_BUS_CTRL_RR_EN`:
  - Defined: round-robin arbitration. On simultaneous req0 and req1 in IDLE, the port not granted last wins, and the pointer updates on every grant. The first tie after reset goes to port 0.
  - Undefined: fixed priority with port 0 always winning, and no pointer register.

## Structure
- Shared package `risc_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - `mem_state_t` enum (IDLE, RD, WR, ACK).
  - Port-index typedef.
- One sub-module, `mem_arb2`: combinational two-requester grant logic plus the round-robin pointer flop under `MEM_BUS_CTRL_RR_EN`.
- The FSM, latches and tri-state driver stay in `mem_bus_ctrl`.

## Test plan
- Write then read on port 1: req1, we1=1, addr1=0x05, wdata1=0xA5 gives ack1 at cycle n+2. Then a read of 0x05 gives rdata1=0xA5 on the ack1 cycle, and rdata0 stays 0.
- Simultaneous request: req0 (read 0x00) and req1 (write 0x1F=0x3C) raised together gives ack0 first and ack1 three cycles later. With RR enabled, a second simultaneous pair is served port 1 first.
- Bus exclusivity: over random traffic, assert mem_rd & mem_wr never both 1, and mem_data is Z from the controller except in WR.
- Back-to-back on one port: req0 held high across 4 reads of 0x00–0x03 gives exactly 4 ack0 pulses, 3 cycles apart, with the correct rdata0 each time.
- Reset mid-write: assert rst_n low during WR to 0x10=0xFF gives outputs at reset values immediately, no ack, and a later read of 0x10 returns the prior value.
- Address wrap: a write to 0x1F then a read of 0x00 returns its own content, with no aliasing.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared widths and types for the data-memory access path (controller, arbiter, requester bundle).
package risc_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } mem_state_t;

  typedef logic port_idx_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Requester-side handshake bundle for mem_bus_ctrl: per-port request payload in, ack and read data out.
interface mem_bus_ctrl_if;
  import risc_pkg::*;

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1
  );

endinterface

// File: rtl/mem_arb2.sv
// Two-requester grant logic. MEM_BUS_CTRL_RR_EN adds a last-grant pointer for round-robin ties;
// without it port 0 always wins.
module mem_arb2
  import risc_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      req0,
  input  logic      req1,
  input  logic      take,
  output port_idx_t gnt_idx_c,
  output logic      gnt_any_c
);

  assign gnt_any_c = req0 | req1;

`ifdef MEM_BUS_CTRL_RR_EN
  port_idx_t last_q;

  // Reset to "port 1 granted last" so the first tie goes to port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= port_idx_t'(1'b1);
    end else if (take) begin
      last_q <= gnt_idx_c;
    end
  end

  assign gnt_idx_c = (req0 && req1) ? ~last_q : port_idx_t'(!req0);
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, take};
  assign gnt_idx_c = port_idx_t'(!req0);
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// Two-port access controller for the 32x8 single-port data memory on a shared tri-state bus.
// Define MEM_BUS_CTRL_RR_EN for round-robin arbitration; the default build uses fixed priority.
module mem_bus_ctrl #(
  parameter int unsigned ADDR_W = risc_pkg::ADDR_W,
  parameter int unsigned DATA_W = risc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  inout  wire  [DATA_W-1:0] mem_data
);
  import risc_pkg::*;

  mem_state_t state_q, state_d;
  mem_req_t   sel_c, lat_q;
  port_idx_t  gnt_idx_c, win_q;
  logic       gnt_any_c, take_c;
  logic       rd_d, wr_d, ack0_d, ack1_d;

  mem_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (bus.req0),
    .req1      (bus.req1),
    .take      (take_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_any_c (gnt_any_c)
  );

  // Payload of whichever port the arbiter is granting this cycle.
  always_comb begin
    sel_c = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
    if (gnt_idx_c == 1'b1) begin
      sel_c = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
    end
  end

  // Next state plus next values of the registered strobes.
  always_comb begin
    state_d = state_q;
    take_c  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any_c) begin
          take_c  = 1'b1;
          state_d = sel_c.we ? WR : RD;
          rd_d    = !sel_c.we;
          wr_d    = sel_c.we;
        end
      end
      RD, WR: begin
        state_d = ACK;
        ack0_d  = (win_q == 1'b0);
        ack1_d  = (win_q == 1'b1);
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes come straight from flops so reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      win_q      <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
    end else begin
      state_q  <= state_d;
      mem_rd   <= rd_d;
      mem_wr   <= wr_d;
      bus.ack0 <= ack0_d;
      bus.ack1 <= ack1_d;
      if (take_c) begin
        lat_q <= sel_c;
        win_q <= gnt_idx_c;
      end
      if (state_q == RD) begin
        if (win_q == 1'b1) begin
          bus.rdata1 <= mem_data;
        end else begin
          bus.rdata0 <= mem_data;
        end
      end
    end
  end

  assign mem_addr = lat_q.addr;
  assign mem_data = (mem_wr && lat_q.we) ? lat_q.wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized self-checking bench for mem_bus_ctrl against a transaction-level memory/arbitration model.
module tb_mem_bus_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
`ifdef MEM_BUS_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  wire  [DW-1:0] mem_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;

  logic [DW-1:0] mem_arr [32];
  logic          mem_load = 1'b1;
  logic [DW-1:0] probe_val = 8'h96;

  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_rd [2];
  logic          last_gnt;

  int errors = 0;
  int checks = 0;

  mem_bus_ctrl_if bus ();

  mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Memory drives on read; an idle probe pattern drives when the controller should be off the bus.
  assign mem_data = mem_rd ? mem_arr[mem_addr] : {DW{1'bz}};
  assign mem_data = (!mem_rd && !mem_wr) ? probe_val : {DW{1'bz}};

  always @(posedge clk) begin
    probe_val <= DW'($urandom);
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= ref_mem[i];
    end else if (mem_wr) begin
      mem_arr[mem_addr] <= mem_data;
    end
  end

  // Bus exclusivity and release checked every cycle.
  always @(negedge clk) begin
    checks++;
    if (mem_rd && mem_wr) begin
      errors++;
      $display("FAIL bus_excl: mem_rd=%b mem_wr=%b, required not both 1", mem_rd, mem_wr);
    end
    if (mem_rd) begin
      checks++;
      if (mem_data !== mem_arr[mem_addr]) begin
        errors++;
        $display("FAIL bus_rd_clean: mem_data=%h, required %h", mem_data, mem_arr[mem_addr]);
      end
    end else if (!mem_wr) begin
      checks++;
      if (mem_data !== probe_val) begin
        errors++;
        $display("FAIL bus_release: mem_data=%h, required probe %h (controller off bus)", mem_data, probe_val);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void serve(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (we) ref_mem[a] = d;
    else exp_rd[p] = ref_mem[a];
    last_gnt = p[0];
  endfunction

  // Expected ack cycle per port (-1 = none) given simultaneous raise at one IDLE cycle.
  function automatic void model(input logic r0, r1, w0, w1, input logic [AW-1:0] a0, a1,
                                input logic [DW-1:0] d0, d1, output int e0, output int e1);
    int first;
    e0 = -1;
    e1 = -1;
    if (r0 && r1) first = (RR && last_gnt == 1'b0) ? 1 : 0;
    else first = r1 ? 1 : 0;
    if (first == 0) begin
      if (r0) begin serve(0, w0, a0, d0); e0 = 2; end
      if (r1) begin serve(1, w1, a1, d1); e1 = r0 ? 5 : 2; end
    end else begin
      serve(1, w1, a1, d1); e1 = 2;
      if (r0) begin serve(0, w0, a0, d0); e0 = 5; end
    end
  endfunction

  task automatic issue(input logic r0, r1, w0, w1, input logic [AW-1:0] a0, a1,
                       input logic [DW-1:0] d0, d1, output int c0, output int c1,
                       output logic [DW-1:0] q0, output logic [DW-1:0] q1);
    @(negedge clk);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    c0 = -1; c1 = -1; q0 = '0; q1 = '0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (bus.ack0) begin
        if (c0 < 0) begin c0 = cyc; q0 = bus.rdata0; end else c0 = 99;
        bus.req0 = 1'b0;
      end
      if (bus.ack1) begin
        if (c1 < 0) begin c1 = cyc; q1 = bus.rdata1; end else c1 = 99;
        bus.req1 = 1'b0;
      end
      if ((!r0 || c0 >= 0) && (!r1 || c1 >= 0)) break;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr, bus.ack0, bus.ack1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: rd/wr/ack0/ack1=%b, required 0000", {mem_rd, mem_wr, bus.ack0, bus.ack1});
    end
    checks++;
    if (mem_addr !== 5'h00) begin
      errors++;
      $display("FAIL reset_addr: mem_addr=%h, required 00", mem_addr);
    end
    checks++;
    if ({bus.rdata0, bus.rdata1} !== {exp_rd[0], exp_rd[1]}) begin
      errors++;
      $display("FAIL reset_rdata: rdata0=%h rdata1=%h, required %h %h", bus.rdata0, bus.rdata1, exp_rd[0], exp_rd[1]);
    end
    mem_load = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int e0, e1, c0, c1;
    logic [DW-1:0] q0, q1;
    model(0, 1, 0, 1, '0, 5'h05, '0, 8'hA5, e0, e1);
    issue(0, 1, 0, 1, '0, 5'h05, '0, 8'hA5, c0, c1, q0, q1);
    checks++;
    if (c0 !== e0 || c1 !== e1) begin
      errors++;
      $display("FAIL wr_p1_ack: ack0/ack1 cycle=%0d/%0d, required %0d/%0d", c0, c1, e0, e1);
    end
    model(0, 1, 0, 0, '0, 5'h05, '0, '0, e0, e1);
    issue(0, 1, 0, 0, '0, 5'h05, '0, '0, c0, c1, q0, q1);
    checks++;
    if (c1 !== e1) begin
      errors++;
      $display("FAIL rd_p1_ack: ack1 cycle=%0d, required %0d", c1, e1);
    end
    checks++;
    if (q1 !== exp_rd[1]) begin
      errors++;
      $display("FAIL rd_p1_data: rdata1=%h, required %h", q1, exp_rd[1]);
    end
    checks++;
    if (bus.rdata0 !== exp_rd[0]) begin
      errors++;
      $display("FAIL rd_p1_rdata0: rdata0=%h, required %h", bus.rdata0, exp_rd[0]);
    end
  endtask

  task automatic test_simultaneous();
    int e0, e1, c0, c1;
    logic [DW-1:0] q0, q1;
    model(1, 1, 0, 1, 5'h00, 5'h1F, '0, 8'h3C, e0, e1);
    issue(1, 1, 0, 1, 5'h00, 5'h1F, '0, 8'h3C, c0, c1, q0, q1);
    checks++;
    if (c0 !== e0 || c1 !== e1) begin
      errors++;
      $display("FAIL sim1_order: ack0/ack1 cycle=%0d/%0d, required %0d/%0d", c0, c1, e0, e1);
    end
    checks++;
    if (q0 !== exp_rd[0]) begin
      errors++;
      $display("FAIL sim1_rdata0: rdata0=%h, required %h", q0, exp_rd[0]);
    end
    model(1, 0, 0, 0, 5'h01, '0, '0, '0, e0, e1);
    issue(1, 0, 0, 0, 5'h01, '0, '0, '0, c0, c1, q0, q1);
    checks++;
    if (c0 !== e0 || q0 !== exp_rd[0]) begin
      errors++;
      $display("FAIL single_p0: ack0 cycle=%0d rdata0=%h, required %0d %h", c0, q0, e0, exp_rd[0]);
    end
    model(1, 1, 0, 0, 5'h02, 5'h1F, '0, '0, e0, e1);
    issue(1, 1, 0, 0, 5'h02, 5'h1F, '0, '0, c0, c1, q0, q1);
    checks++;
    if (c0 !== e0 || c1 !== e1) begin
      errors++;
      $display("FAIL sim2_order: ack0/ack1 cycle=%0d/%0d, required %0d/%0d", c0, c1, e0, e1);
    end
    checks++;
    if (q0 !== exp_rd[0] || q1 !== exp_rd[1]) begin
      errors++;
      $display("FAIL sim2_data: rdata0=%h rdata1=%h, required %h %h", q0, q1, exp_rd[0], exp_rd[1]);
    end
  endtask

  task automatic test_back_to_back();
    int n, extra;
    int cyc_at [4];
    logic [DW-1:0] q [4];
    logic [DW-1:0] e [4];
    for (int i = 0; i < 4; i++) begin
      cyc_at[i] = -1;
      serve(0, 1'b0, AW'(i), '0);
      e[i] = exp_rd[0];
    end
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = '0; bus.req1 = 1'b0;
    n = 0;
    for (int cyc = 1; cyc <= 20 && n < 4; cyc++) begin
      @(negedge clk);
      if (bus.ack0) begin
        cyc_at[n] = cyc;
        q[n] = bus.rdata0;
        n++;
        if (n == 4) bus.req0 = 1'b0;
        else bus.addr0 = AW'(n);
      end
    end
    bus.req0 = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) extra++;
    end
    checks++;
    if (n !== 4 || extra !== 0) begin
      errors++;
      $display("FAIL b2b_count: acks=%0d stray=%0d, required 4 and 0", n, extra);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (cyc_at[i] !== 2 + 3 * i || q[i] !== e[i]) begin
        errors++;
        $display("FAIL b2b_%0d: cycle=%0d rdata0=%h, required %0d %h", i, cyc_at[i], q[i], 2 + 3 * i, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int e0, e1, c0, c1, extra;
    logic [DW-1:0] q0, q1;
    model(1, 0, 1, 0, 5'h10, '0, 8'h5A, '0, e0, e1);
    issue(1, 0, 1, 0, 5'h10, '0, 8'h5A, '0, c0, c1, q0, q1);
    checks++;
    if (c0 !== e0) begin
      errors++;
      $display("FAIL pre_write: ack0 cycle=%0d, required %0d", c0, e0);
    end
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'h10; bus.wdata0 = 8'hFF;
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b1 || mem_data !== 8'hFF) begin
      errors++;
      $display("FAIL wr_phase: mem_wr=%b mem_data=%h, required 1 FF", mem_wr, mem_data);
    end
    #1 rst_n = 1'b0;
    #1;
    exp_rd[0] = '0; exp_rd[1] = '0; last_gnt = 1'b1;
    checks++;
    if ({mem_rd, mem_wr, bus.ack0, bus.ack1} !== 4'b0000 || mem_addr !== 5'h00) begin
      errors++;
      $display("FAIL async_reset: rd/wr/ack0/ack1=%b addr=%h, required 0000 00",
               {mem_rd, mem_wr, bus.ack0, bus.ack1}, mem_addr);
    end
    checks++;
    if (mem_data !== probe_val || {bus.rdata0, bus.rdata1} !== {exp_rd[0], exp_rd[1]}) begin
      errors++;
      $display("FAIL async_reset_bus: mem_data=%h rdata=%h/%h, required %h %h/%h",
               mem_data, bus.rdata0, bus.rdata1, probe_val, exp_rd[0], exp_rd[1]);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL no_ack_after_reset: stray acks=%0d, required 0", extra);
    end
    model(1, 0, 0, 0, 5'h10, '0, '0, '0, e0, e1);
    issue(1, 0, 0, 0, 5'h10, '0, '0, '0, c0, c1, q0, q1);
    checks++;
    if (c0 !== e0 || q0 !== exp_rd[0]) begin
      errors++;
      $display("FAIL aborted_write: ack0 cycle=%0d rdata0=%h, required %0d %h", c0, q0, e0, exp_rd[0]);
    end
  endtask

  task automatic test_wrap();
    int e0, e1, c0, c1;
    logic [DW-1:0] q0, q1, v;
    v = DW'($urandom);
    model(0, 1, 0, 1, '0, 5'h1F, '0, v, e0, e1);
    issue(0, 1, 0, 1, '0, 5'h1F, '0, v, c0, c1, q0, q1);
    model(1, 0, 1, 0, 5'h00, '0, ~v, '0, e0, e1);
    issue(1, 0, 1, 0, 5'h00, '0, ~v, '0, c0, c1, q0, q1);
    model(1, 0, 0, 0, 5'h00, '0, '0, '0, e0, e1);
    issue(1, 0, 0, 0, 5'h00, '0, '0, '0, c0, c1, q0, q1);
    checks++;
    if (c0 !== e0 || q0 !== exp_rd[0]) begin
      errors++;
      $display("FAIL wrap_low: ack0 cycle=%0d rdata0=%h, required %0d %h", c0, q0, e0, exp_rd[0]);
    end
    model(0, 1, 0, 0, '0, 5'h1F, '0, '0, e0, e1);
    issue(0, 1, 0, 0, '0, 5'h1F, '0, '0, c0, c1, q0, q1);
    checks++;
    if (c1 !== e1 || q1 !== exp_rd[1]) begin
      errors++;
      $display("FAIL wrap_high: ack1 cycle=%0d rdata1=%h, required %0d %h", c1, q1, e1, exp_rd[1]);
    end
  endtask

  task automatic test_random();
    int e0, e1, c0, c1;
    logic [DW-1:0] q0, q1, d0, d1;
    logic r0, r1, w0, w1;
    logic [AW-1:0] a0, a1;
    for (int t = 0; t < 50; t++) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      w0 = 1'($urandom); w1 = 1'($urandom);
      a0 = AW'($urandom); a1 = AW'($urandom);
      d0 = DW'($urandom); d1 = DW'($urandom);
      model(r0, r1, w0, w1, a0, a1, d0, d1, e0, e1);
      issue(r0, r1, w0, w1, a0, a1, d0, d1, c0, c1, q0, q1);
      checks++;
      if (c0 !== e0 || c1 !== e1) begin
        errors++;
        $display("FAIL rand_%0d_ack: ack0/ack1 cycle=%0d/%0d, required %0d/%0d", t, c0, c1, e0, e1);
      end
      if (r0) begin
        checks++;
        if (q0 !== exp_rd[0]) begin
          errors++;
          $display("FAIL rand_%0d_rdata0: rdata0=%h, required %h", t, q0, exp_rd[0]);
        end
      end
      if (r1) begin
        checks++;
        if (q1 !== exp_rd[1]) begin
          errors++;
          $display("FAIL rand_%0d_rdata1: rdata1=%h, required %h", t, q1, exp_rd[1]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = DW'($urandom);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_gnt  = 1'b1;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_write();
    test_wrap();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
